// File: rtl/tb_mem_arbiter_pkg.sv
// tb_mem_arbiter_pkg: shared types and default constants for the SRAM arbiter
package tb_mem_arbiter_pkg;
  localparam int ADDR_W = 21;
  localparam int DATA_W = 128;
  localparam int CTRL_STOP = 0;
  localparam int CTRL_LOG_START = 8;
  localparam int CTRL_LOG_STOP = 16;
  typedef logic [ADDR_W-1:0] addr_t;
  typedef logic [DATA_W-1:0] data_t;
  typedef logic [DATA_W-1:0] strb_t;
  typedef enum logic [1:0] {RUN, DRAIN, DONE} state_e;
  typedef struct packed {
    logic  we;
    addr_t addr;
    data_t wdata;
    strb_t strb;
  } req_t;
endpackage

// File: rtl/tb_mem_arbiter_rr_arb2.sv
// rr_arb2: two-way round-robin arbiter with one-hot grant
module rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       en,
  input  logic [1:0] req,
  output logic [1:0] gnt
);
  logic ptr;
  // pointer only matters when both ports ask at once
  always_comb gnt = !en ? 2'b00 : &req ? (ptr ? 2'b10 : 2'b01) : req;
  // hand priority to the loser after every contended grant
  always_ff @(posedge clk_i)
    if (!rst_ni) ptr <= 1'b0;
    else if (en && &req) ptr <= ~ptr;
endmodule

// File: rtl/tb_mem_arbiter.sv
// tb_mem_arbiter: shares one SRAM between CPU and debug ports, decodes control writes, sequences end-of-run
module tb_mem_arbiter
  import tb_mem_arbiter_pkg::*;
#(
  parameter int                    ADDR_WIDTH     = ADDR_W,
  parameter int                    DATA_WIDTH     = DATA_W,
  parameter int                    STOP_DRAIN     = 50,
  parameter logic [ADDR_WIDTH-1:0] ADDR_STOP      = ADDR_WIDTH'(CTRL_STOP),
  parameter logic [ADDR_WIDTH-1:0] ADDR_LOG_START = ADDR_WIDTH'(CTRL_LOG_START),
  parameter logic [ADDR_WIDTH-1:0] ADDR_LOG_STOP  = ADDR_WIDTH'(CTRL_LOG_STOP)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req0_i,
  input  logic                  req1_i,
  input  logic                  we0_i,
  input  logic                  we1_i,
  input  logic [ADDR_WIDTH-1:0] addr0_i,
  input  logic [ADDR_WIDTH-1:0] addr1_i,
  input  logic [DATA_WIDTH-1:0] wdata0_i,
  input  logic [DATA_WIDTH-1:0] wdata1_i,
  input  logic [DATA_WIDTH-1:0] strb0_i,
  input  logic [DATA_WIDTH-1:0] strb1_i,
  output logic                  gnt0_o,
  output logic                  gnt1_o,
  output logic                  rvalid0_o,
  output logic                  rvalid1_o,
  output logic [DATA_WIDTH-1:0] rdata0_o,
  output logic [DATA_WIDTH-1:0] rdata1_o,
  output logic                  sram_req_o,
  output logic                  sram_we_o,
  output logic [ADDR_WIDTH-1:0] sram_addr_o,
  output logic [DATA_WIDTH-1:0] sram_wdata_o,
  output logic [DATA_WIDTH-1:0] sram_strb_o,
  input  logic [DATA_WIDTH-1:0] sram_rdata_i,
  output logic                  stop_req_o,
  output logic                  log_en_o,
  output logic                  done_o
);
  localparam int CW = STOP_DRAIN > 0 ? $clog2(STOP_DRAIN + 1) : 1;
  state_e        state;
  logic [CW-1:0] cnt;
  logic          is_ctrl, fin, en, pend0, pend1;
  logic [1:0]    g;
  assign is_ctrl = req0_i & we0_i & (addr0_i == ADDR_STOP | addr0_i == ADDR_LOG_START | addr0_i == ADDR_LOG_STOP);
  assign fin = state == DONE | (state == DRAIN & cnt == '0);
  assign en = rst_ni & ~fin;
  rr_arb2 u_arb (
    .clk_i (clk_i),
    .rst_ni(rst_ni),
    .en    (en),
    .req   ({req1_i, req0_i & ~is_ctrl}),
    .gnt   (g)
  );
  assign gnt0_o = g[0] | (en & is_ctrl);
  assign gnt1_o = g[1];
  assign sram_req_o = |g;
  assign sram_we_o = g[0] ? we0_i : g[1] & we1_i;
  assign sram_addr_o = g[0] ? addr0_i : g[1] ? addr1_i : '0;
  assign sram_wdata_o = g[0] ? wdata0_i : g[1] ? wdata1_i : '0;
  assign sram_strb_o = g[0] ? strb0_i : g[1] ? strb1_i : '0;
  assign rvalid0_o = rst_ni & pend0;
  assign rvalid1_o = rst_ni & pend1;
  assign rdata0_o = rvalid0_o ? sram_rdata_i : '0;
  assign rdata1_o = rvalid1_o ? sram_rdata_i : '0;
  assign done_o = fin;
  // remember which port owns the SRAM read returning next cycle
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      pend0 <= 1'b0;
      pend1 <= 1'b0;
    end else begin
      pend0 <= g[0] & ~we0_i;
      pend1 <= g[1] & ~we1_i;
    end
  // control decode and end-of-run sequencing; log window frozen once stopping
  always_ff @(posedge clk_i)
    if (!rst_ni) begin
      state      <= RUN;
      cnt        <= '0;
      stop_req_o <= 1'b0;
      log_en_o   <= 1'b0;
    end else if (state == RUN && is_ctrl) begin
      if (addr0_i == ADDR_STOP) begin
        state      <= DRAIN;
        cnt        <= CW'(STOP_DRAIN);
        stop_req_o <= 1'b1;
      end
      if (addr0_i == ADDR_LOG_START) log_en_o <= 1'b1;
      if (addr0_i == ADDR_LOG_STOP) log_en_o <= 1'b0;
    end else if (state == DRAIN) begin
      cnt <= cnt - CW'(1);
      if (cnt == '0) state <= DONE;
    end
endmodule

// File: doc/tb_mem_arbiter.md
Name: tb_mem_arbiter

Overview:
- Shares the tiny SoC's single-port 128-bit SRAM between two requesters: port 0, the CPU memory interface, and port 1, the bench preload/debug port.
- Decodes CPU writes to control addresses (stop, BHT-log start, BHT-log stop) into sticky status outputs.
- Sequences end-of-run: after a stop write, it drains for a fixed number of cycles, then blocks all traffic and raises done.

Parameters:
- ADDR_WIDTH, 21, SRAM word-address width.
- DATA_WIDTH, 128, SRAM data and strobe width.
- STOP_DRAIN, 50, cycles between the stop write and done_o.
- ADDR_STOP, 0, control address: stop request.
- ADDR_LOG_START, 8, control address: set log_en_o.
- ADDR_LOG_STOP, 16, control address: clear log_en_o.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, synchronous, active-low
- req0_i/req1_i  in  1  port request
- we0_i/we1_i  in  1  write enable
- addr0_i/addr1_i  in  ADDR_WIDTH  address
- wdata0_i/wdata1_i  in  DATA_WIDTH  write data
- strb0_i/strb1_i  in  DATA_WIDTH  bit strobe
- gnt0_o/gnt1_o  out  1  grant, same cycle as the request
- rvalid0_o/rvalid1_o  out  1  read data valid
- rdata0_o/rdata1_o  out  DATA_WIDTH  read data
- sram_req_o, sram_we_o  out  1  SRAM request and write enable
- sram_addr_o  out  ADDR_WIDTH  SRAM address
- sram_wdata_o, sram_strb_o  out  DATA_WIDTH  SRAM write data and strobe
- sram_rdata_i  in  DATA_WIDTH  SRAM read data, valid one cycle after a read request
- stop_req_o  out  1  sticky: stop write seen
- log_en_o  out  1  BHT logging window active
- done_o  out  1  sticky: drain complete

Behaviour:
- Clock and reset: one clock, clk_i. Reset is synchronous and active-low on rst_ni.
- Reset values: every output is 0, state is RUN, the round-robin pointer favours port 0, and the pending-read flags are cleared. A reset mid-operation discards any pending rvalid.
- Control write: req0_i=1, we0_i=1 and addr0_i equal to one of the three control addresses. A control write is granted but never forwarded to the SRAM. Port 1 control-address writes are ordinary SRAM writes.
- Arbitration: grant is combinational.
  - Only one port requests an SRAM access: that port is granted.
  - Both request: the port selected by the round-robin pointer is granted. The pointer then moves to the other port, and it updates only on a contended grant.
  - Port 0 is granted a control write: port 1, if requesting, is also granted in the same cycle and owns the SRAM.
- SRAM drive: sram_* mirrors the granted SRAM port's request. When there is no SRAM grant, sram_req_o=0 and the address and data fields are 0.
- Reads: a read granted in cycle t gives rvalidN_o=1 in cycle t+1, with rdataN_o=sram_rdata_i. When rvalidN_o=0, rdataN_o=0. Writes produce no rvalid. Back-to-back reads are supported at one per cycle per SRAM slot.
- State machine:
  - RUN: a control write to ADDR_STOP moves to DRAIN, sets stop_req_o and loads cnt=STOP_DRAIN. A write to ADDR_LOG_START sets log_en_o, and a write to ADDR_LOG_STOP clears it.
  - DRAIN: arbitration continues normally. cnt decrements by 1 each cycle. In the cycle with cnt==0 the block moves to DONE. Log writes and further stop writes are granted but ignored, so log_en_o is frozen.
  - DONE: done_o=1 and all gnt outputs are 0, so sram_req_o=0. A read granted in the last DRAIN cycle still returns its rvalid. The block leaves DONE only on reset.
- Counter: width is clog2(STOP_DRAIN+1). With STOP_DRAIN=0, the block enters DONE in the cycle after the stop write.
- Ungranted requests: the arbiter has no request queue. A requester must hold its request stable until it is granted.

Decomposition:
- Package tb_mem_arbiter_pkg holds:
  - addr_t, data_t, strb_t;
  - the state enum (RUN, DRAIN, DONE);
  - the default control-address constants;
  - a req_t struct bundling we/addr/wdata/strb.
- Sub-module rr_arb2: 2-way round-robin arbiter.
  - Inputs: req[1:0], and an enable that is 0 in DONE.
  - Outputs: a one-hot gnt[1:0].
  - Holds the pointer flop internally and updates it on contended grants.

Test Plan:
- Port 0 writes 0xA5.. to addr 0x40, then reads 0x40: gnt0_o=1 both cycles; rvalid0_o=1 with 0xA5.. one cycle after the read; port 1 stays idle.
- Both ports read continuously for 4 cycles: grants alternate 0,1,0,1; each rvalid follows its grant by one cycle on the matching port.
- Port 0 writes addr 8 while port 1 reads addr 0x100 in the same cycle: both are granted; the SRAM sees only the port 1 read; log_en_o=1 next cycle. A later write to addr 16 clears log_en_o.
- Port 0 writes addr 0: stop_req_o=1 next cycle; done_o rises exactly STOP_DRAIN+1=51 cycles after the write; after that gnt0_o and gnt1_o stay 0 and sram_req_o stays 0 under continuous requests.
- A write to addr 8 during DRAIN: log_en_o is unchanged. A port 1 write to addr 0 in RUN goes to the SRAM, and stop_req_o stays 0.
- Assert rst_ni low for one cycle in DRAIN, with a read in flight: next cycle all outputs are 0, no rvalid is produced, state is RUN, and traffic resumes normally.
